// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the SLC-3 test-memory arbiter.
package mem_arb_pkg;

  localparam int NUM_REQ = 2;
  // Latency counter width; holds READ_LAT values 1..7.
  localparam int LAT_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-port round-robin pick. The 'last' input is the most recently granted
// port, so on a tie the other port wins. The pointer register lives in the
// caller; this block is purely combinational.
import mem_arb_pkg::*;

module rr_arbiter2 (
  input  logic [NUM_REQ-1:0] req,
  input  logic               last,
  output logic [NUM_REQ-1:0] winner,
  output logic               next_last
);

  // One-hot winner and the pointer value to store if this grant is taken.
  always_comb begin
    winner    = '0;
    next_last = last;
    case (req)
      2'b01:   winner = 2'b01;
      2'b10:   winner = 2'b10;
      2'b11:   winner = last ? 2'b01 : 2'b10;
      default: winner = '0;
    endcase
    if (winner[1]) begin
      next_last = 1'b1;
    end else if (winner[0]) begin
      next_last = 1'b0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter and sequencer for the single-port SLC-3 test memory. Port 0 is the
// CPU, port 1 the debug/loader. One access in flight at a time; reads wait a
// fixed READ_LAT cycles before the data is captured.
//
// Handshake: a requester raises req_i[p] with we/addr/wdata stable and holds
// them until done_o[p] pulses. gnt_o[p] pulses in the issue cycle; done_o[p]
// pulses once when the access is complete (rdata_o valid with it for reads).
// Dropping req_i after the grant does not cancel the access.
import mem_arb_pkg::*;

module mem_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 16,
  parameter int READ_LAT = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          req_i,
  input  logic [1:0]          we_i,
  input  logic [15:0]         addr0_i,
  input  logic [15:0]         addr1_i,
  input  logic [DATA_W-1:0]   wdata0_i,
  input  logic [DATA_W-1:0]   wdata1_i,
  output logic [1:0]          gnt_o,
  output logic [1:0]          done_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                busy_o,
  output logic                mem_ena_o,
  output logic                mem_wren_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output state_t              dbg_state_o
);

  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(READ_LAT);

  state_t             state;
  logic               last;
  logic [1:0]         owner;
  logic [LAT_W-1:0]   cnt;
  logic [1:0]         winner;
  logic               next_last;

  // Upper address bits are deliberately discarded (memory is ADDR_W deep).
  logic unused_addr_hi;
  assign unused_addr_hi = ^{addr0_i[15:ADDR_W], addr1_i[15:ADDR_W]};

  assign dbg_state_o = state;

  rr_arbiter2 u_rr (
    .req       (req_i),
    .last      (last),
    .winner    (winner),
    .next_last (next_last)
  );

  // Main sequencer: arbitrate in IDLE, issue one access, count read latency,
  // pulse done. gnt/done/ena are single-cycle pulses defaulting low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      last        <= 1'b1;
      owner       <= '0;
      cnt         <= '0;
      gnt_o       <= '0;
      done_o      <= '0;
      rdata_o     <= '0;
      busy_o      <= 1'b0;
      mem_ena_o   <= 1'b0;
      mem_wren_o  <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      gnt_o     <= '0;
      done_o    <= '0;
      mem_ena_o <= 1'b0;
      case (state)
        IDLE: begin
          if (|req_i) begin
            owner       <= winner;
            last        <= next_last;
            gnt_o       <= winner;
            mem_ena_o   <= 1'b1;
            mem_wren_o  <= winner[1] ? we_i[1] : we_i[0];
            mem_addr_o  <= winner[1] ? addr1_i[ADDR_W-1:0] : addr0_i[ADDR_W-1:0];
            mem_wdata_o <= winner[1] ? wdata1_i : wdata0_i;
            busy_o      <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_wren_o) begin
            // Write lands at the end of the issue cycle; finish next cycle.
            mem_wren_o <= 1'b0;
            done_o     <= owner;
            state      <= DONE;
          end else begin
            cnt   <= LAT_INIT;
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          // cnt==1 marks cycle T+READ_LAT, when memory data is valid.
          if (cnt == LAT_W'(1)) begin
            rdata_o <= mem_rdata_i;
            done_o  <= owner;
            state   <= DONE;
          end
        end
        DONE: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 2-cycle-latency memory.
import mem_arb_pkg::*;

module tb_mem_arbiter;

  localparam int READ_LAT = 2;

  logic        clk;
  logic        reset;
  logic [1:0]  req_i;
  logic [1:0]  we_i;
  logic [15:0] addr0_i, addr1_i;
  logic [15:0] wdata0_i, wdata1_i;
  logic [1:0]  gnt_o, done_o;
  logic [15:0] rdata_o;
  logic        busy_o, mem_ena_o, mem_wren_o;
  logic [9:0]  mem_addr_o;
  logic [15:0] mem_wdata_o, mem_rdata_i;
  state_t      dbg_state_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_rd;
  logic [1:0]  exp_q[$];

  mem_arbiter #(.ADDR_W(10), .DATA_W(16), .READ_LAT(READ_LAT)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_i       (req_i),
    .we_i        (we_i),
    .addr0_i     (addr0_i),
    .addr1_i     (addr1_i),
    .wdata0_i    (wdata0_i),
    .wdata1_i    (wdata1_i),
    .gnt_o       (gnt_o),
    .done_o      (done_o),
    .rdata_o     (rdata_o),
    .busy_o      (busy_o),
    .mem_ena_o   (mem_ena_o),
    .mem_wren_o  (mem_wren_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .dbg_state_o (dbg_state_o)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: data valid during cycle T+2 after an issue in cycle T.
  logic [15:0] mem [0:1023];
  logic        v1, v2;
  logic [9:0]  a1, a2;
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
  end
  always @(posedge clk) begin
    if (mem_ena_o && mem_wren_o) mem[mem_addr_o] <= mem_wdata_o;
  end
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1 <= 1'b0; v2 <= 1'b0; a1 <= '0; a2 <= '0;
    end else begin
      v1 <= mem_ena_o && !mem_wren_o;
      a1 <= mem_addr_o;
      v2 <= v1;
      a2 <= a1;
    end
  end
  assign mem_rdata_i = v2 ? mem[a2] : 16'hDEAD;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [1:0] onehot(input int port);
    return (port == 0) ? 2'b01 : 2'b10;
  endfunction

  // One complete access on a single port with timing and data checks.
  task automatic run_access(input int port, input logic we, input logic [15:0] addr,
                            input logic [15:0] wdata, input bit drop_early);
    bit seen;
    int k;
    int extra_ena;
    req_i[port] = 1'b1;
    we_i[port]  = we;
    if (port == 0) begin addr0_i = addr; wdata0_i = wdata; end
    else           begin addr1_i = addr; wdata1_i = wdata; end
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (gnt_o[port]) seen = 1;
    end
    check("gnt_seen", 32'(seen), 32'd1);
    if (!seen) begin
      req_i[port] = 1'b0;
      return;
    end
    check("gnt_port", 32'(gnt_o), 32'(onehot(port)));
    check("issue_ena", 32'(mem_ena_o), 32'd1);
    check("issue_wren", 32'(mem_wren_o), 32'(we));
    check("issue_addr", 32'(mem_addr_o), 32'(addr[9:0]));
    if (we) check("issue_wdata", 32'(mem_wdata_o), 32'(wdata));
    k = 0;
    extra_ena = 0;
    do begin
      tick();
      k++;
      if (drop_early && k == 1) req_i[port] = 1'b0;
      if (mem_ena_o) extra_ena++;
    end while (done_o == 2'b00 && k < 20);
    check("done_lat", 32'(k), we ? 32'd1 : 32'(READ_LAT + 1));
    check("done_port", 32'(done_o), 32'(onehot(port)));
    check("single_ena", 32'(extra_ena), 32'd0);
    if (!we) exp_rd = mem[addr[9:0]];
    check("rdata", 32'(rdata_o), 32'(exp_rd));
    req_i[port] = 1'b0;
    tick();
    check("busy_idle", 32'(busy_o), 32'd0);
    check("done_clear", 32'(done_o), 32'd0);
  endtask

  int gcount, dcount, cyc, last_issue;
  logic [1:0] owner;
  logic prev_ena;

  initial begin
    reset = 1'b0; req_i = 2'b11; we_i = 2'b00;
    addr0_i = 16'h0; addr1_i = 16'h0; wdata0_i = 16'h0; wdata1_i = 16'h0;
    exp_rd = 16'h0;

    // 1. Reset with both requesting; first grant goes to port 0.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_ctl", {27'd0, gnt_o, done_o, mem_ena_o}, 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_data", {mem_wren_o, mem_addr_o, rdata_o}, 32'd0);
      check("rst_wdata", 32'(mem_wdata_o), 32'd0);
      check("rst_state", 32'(dbg_state_o), 32'(IDLE));
    end
    reset = 1'b1;
    tick();
    check("first_gnt", 32'(gnt_o), 32'b01);
    req_i = 2'b00;
    for (int i = 0; i < 20 && busy_o; i++) tick();
    check("t1_idle", 32'(busy_o), 32'd0);
    tick();

    // 2. Port 0 write then port 1 read-back.
    run_access(0, 1'b1, 16'h0005, 16'hBEEF, 0);
    run_access(1, 1'b0, 16'h0005, 16'h0000, 0);
    check("readback", 32'(rdata_o), 32'hBEEF);

    // 3. Continuous tie: expect alternating grants 0,1,0,1.
    exp_q.push_back(2'b01); exp_q.push_back(2'b10);
    exp_q.push_back(2'b01); exp_q.push_back(2'b10);
    addr0_i = 16'h0005; addr1_i = 16'h0005; we_i = 2'b00; req_i = 2'b11;
    gcount = 0; dcount = 0; cyc = 0; last_issue = -1; owner = 2'b00; prev_ena = 1'b0;
    while (dcount < 4 && cyc < 80) begin
      tick();
      cyc++;
      check("ena_consec", 32'(mem_ena_o & prev_ena), 32'd0);
      prev_ena = mem_ena_o;
      if (gnt_o != 2'b00) begin
        if (exp_q.size() > 0) check("tie_order", 32'(gnt_o), 32'(exp_q.pop_front()));
        if (last_issue >= 0) check("issue_gap", 32'(cyc - last_issue), 32'(READ_LAT + 3));
        last_issue = cyc;
        owner = gnt_o;
        gcount++;
        if (gcount == 4) req_i = 2'b00;
      end
      if (done_o != 2'b00) begin
        check("done_owner", 32'(done_o), 32'(owner));
        check("tie_rdata", 32'(rdata_o), 32'hBEEF);
        dcount++;
      end
    end
    check("tie_count", 32'(dcount), 32'd4);
    tick();
    check("tie_idle", 32'(busy_o), 32'd0);

    // 4. Address truncation: 0x0405 aliases 0x005.
    run_access(1, 1'b1, 16'h0405, 16'h1234, 0);
    run_access(0, 1'b0, 16'h0005, 16'h0000, 0);
    check("trunc_rdata", 32'(rdata_o), 32'h1234);

    // 5. Withdrawal after grant still completes.
    run_access(1, 1'b1, 16'h03FF, 16'h5A5A, 0);
    run_access(0, 1'b0, 16'h03FF, 16'h0000, 1);
    check("wd_rdata", 32'(rdata_o), 32'h5A5A);

    // 6. Reset in WAIT, then port 1 completes normally.
    req_i = 2'b10; we_i = 2'b00; addr1_i = 16'h0005;
    begin
      bit seen6;
      seen6 = 0;
      for (int i = 0; i < 20 && !seen6; i++) begin
        tick();
        if (gnt_o[1]) seen6 = 1;
      end
      check("t6_gnt", 32'(seen6), 32'd1);
    end
    tick();
    check("t6_in_wait", 32'(dbg_state_o), 32'(WAIT));
    reset = 1'b0;
    #1;
    check("t6_ctl", {27'd0, gnt_o, done_o, mem_ena_o}, 32'd0);
    check("t6_busy", 32'(busy_o), 32'd0);
    check("t6_wren", 32'(mem_wren_o), 32'd0);
    check("t6_state", 32'(dbg_state_o), 32'(IDLE));
    exp_rd = 16'h0000;
    check("t6_rdata", 32'(rdata_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_no_done", 32'(done_o), 32'd0);
    end
    reset = 1'b1;
    run_access(1, 1'b0, 16'h03FF, 16'h0000, 0);
    check("t6_rdata_end", 32'(rdata_o), 32'h5A5A);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    n_errors++;
    $display("FAIL timeout: simulation did not finish");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port SLC-3 test memory (10-bit address, 16-bit data, ena/wren).
- Requester 0 is the SLC-3 CPU memory interface. Requester 1 is a debug/loader port, which fills or inspects memory from the switches.
- Performs round-robin arbitration, issues exactly one memory access at a time, counts fixed read latency, and returns a done pulse and read data to the owner.

Parameters:
- ADDR_W, 10: memory address width; requester addresses are truncated to the low ADDR_W bits.
- DATA_W, 16: data width.
- READ_LAT, 2: cycles from the issue cycle T until mem_rdata_i is valid (valid during cycle T+READ_LAT); legal range 1..7.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- req_i  in  2  request per port; held with we/addr/wdata stable until that port's done_o.
- we_i  in  2  1 = write, 0 = read, per port.
- addr0_i, addr1_i  in  16  per-port address.
- wdata0_i, wdata1_i  in  DATA_W  per-port write data.
- gnt_o  out  2  one-cycle pulse: request accepted (issue cycle).
- done_o  out  2  one-cycle pulse: access complete.
- rdata_o  out  DATA_W  read data; valid with a read done_o and held until the next read completes.
- busy_o  out  1  high while state != IDLE.
- mem_ena_o  out  1  memory enable, exactly one cycle per access.
- mem_wren_o  out  1  memory write enable.
- mem_addr_o  out  ADDR_W  memory address.
- mem_wdata_o  out  DATA_W  memory write data.
- mem_rdata_i  in  DATA_W  memory read data.

Behaviour:
- All outputs are registered. Reset value of every output is 0; the round-robin pointer resets to "last = 1", so port 0 wins the first tie.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Any request at edge E: select the winner, latch its we/addr[ADDR_W-1:0]/wdata, then enter ISSUE.
- ISSUE (cycle T, the cycle after E):
  - gnt_o[w]=1, mem_ena_o=1, mem_wren_o=we, mem_addr_o/mem_wdata_o = latched values.
  - Write: go to DONE.
  - Read: load the counter with READ_LAT and go to WAIT.
- WAIT:
  - mem_ena_o=0; address, data and wren are held; decrement the counter.
  - At the edge ending cycle T+READ_LAT: capture mem_rdata_i into rdata_o and go to DONE.
- DONE: done_o[w]=1 for one cycle, then IDLE.
- Timing:
  - Write done in T+1.
  - Read done in T+READ_LAT+1.
  - Minimum gap between issues: 3 cycles (write) or READ_LAT+3 cycles (read).
- Arbitration:
  - A single requester always wins.
  - Both requesting: the grant goes to the port not granted last. The pointer updates on every grant, so continuous requests on both ports alternate 0,1,0,1 with no starvation.
- Requests are only sampled in IDLE. A req held high through its own DONE cycle is treated as a new request at the next IDLE edge.
- Deasserting req after grant does not abort: the access completes and done_o still pulses.
- Write never modifies rdata_o.
- Reset asserted mid-operation, in any state:
  - Immediate (asynchronous) return to IDLE; mem_ena_o/mem_wren_o/gnt_o/done_o drop at once.
  - No done_o for the aborted access.
  - Pointer is reinitialised.

Decomposition:
- Package mem_arb_pkg:
  - enum state_t {IDLE, ISSUE, WAIT, DONE};
  - localparam NUM_REQ=2.
  - Latency counter width constant, 3 bits.
- Sub-module rr_arbiter2:
  - Inputs: req[1:0] and the pointer.
  - Outputs: one-hot winner and next pointer.
  - Pointer register stays in mem_arbiter; rr_arbiter2 is combinational.

Test Plan:
1. Reset and idle: hold reset=0 for 3 cycles with req_i=2'b11 → all outputs 0, busy_o=0; release → gnt_o=2'b01 on the first grant.
2. Write then read-back: port 0 writes addr 0x0005, data 0xBEEF.
   - Expect mem_ena_o=1, mem_wren_o=1, mem_addr_o=0x005, mem_wdata_o=0xBEEF for exactly one cycle, then done_o[0] in T+1.
   - Port 1 then reads 0x0005 → done_o[1] in T+3, rdata_o=0xBEEF.
3. Tie and fairness: both ports request reads continuously for 4 transactions → grant order 0,1,0,1; each done matches its gnt port; mem_ena_o never high on two consecutive cycles.
4. Address truncation: port 1 writes 0x0405 with data 0x1234, port 0 reads 0x0005 → mem_addr_o=0x005 both times, rdata_o=0x1234.
5. Request withdrawal: port 0 drops req the cycle after gnt_o[0] on a read → done_o[0] still pulses at T+3 and busy_o returns to 0.
6. Reset mid-read: assert reset in WAIT → outputs clear immediately and no done_o; release with port 1 still requesting → port 1 granted, completes normally.
